// File: rtl/gpu_cmd_pkg.sv
// Shared constants for the GPU command front end: opcodes, register map,
// parameter field widths and the command decode used by the dispatcher.
package gpu_cmd_pkg;

  localparam logic [3:0] OP_START = 4'd0;
  localparam logic [3:0] OP_WRITE = 4'd2;
  localparam logic [3:0] OP_FLUSH = 4'd4;
  localparam logic [3:0] OP_RESET = 4'd5;
  localparam logic [3:0] OP_FENCE = 4'd6;

  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_COLOR  = 4'd1;
  localparam logic [3:0] REG_A01    = 4'd2;
  localparam logic [3:0] REG_A12    = 4'd3;
  localparam logic [3:0] REG_A20    = 4'd4;
  localparam logic [3:0] REG_W0     = 4'd5;
  localparam logic [3:0] REG_W1     = 4'd6;
  localparam logic [3:0] REG_W2     = 4'd7;
  localparam logic [3:0] REG_BASE   = 4'd8;
  localparam logic [3:0] REG_STRIDE = 4'd9;
  localparam logic [3:0] REG_B01    = 4'd10;
  localparam logic [3:0] REG_B12    = 4'd11;
  localparam logic [3:0] REG_B20    = 4'd12;
  localparam logic [3:0] REG_ZX     = 4'd13;
  localparam logic [3:0] REG_ZY     = 4'd14;
  localparam logic [3:0] REG_ZC     = 4'd15;

  localparam int COLOR_W  = 16;
  localparam int EDGE_A_W = 19;
  localparam int EDGE_B_W = 24;
  localparam int WORD_W   = 32;
  localparam int STRIDE_W = 16;

  typedef enum logic [2:0] {
    CMD_REG   = 3'd0,
    CMD_START = 3'd1,
    CMD_WRITE = 3'd2,
    CMD_FLUSH = 3'd3,
    CMD_RSTST = 3'd4,
    CMD_FENCE = 3'd5,
    CMD_BAD   = 3'd6
  } cmd_kind_e;

  function automatic cmd_kind_e decode_cmd(input logic [3:0] addr, input logic [3:0] op);
    cmd_kind_e k;
    if (addr != REG_CTRL) begin
      k = CMD_REG;
    end else begin
      case (op)
        OP_START: k = CMD_START;
        OP_WRITE: k = CMD_WRITE;
        OP_FLUSH: k = CMD_FLUSH;
        OP_RESET: k = CMD_RSTST;
        OP_FENCE: k = CMD_FENCE;
        default:  k = CMD_BAD;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/gpu_lane_tracker.sv
// Per-lane dispatch bookkeeping: dirty flags, ping-pong buffer selects and the
// round-robin start / write-back pointers, plus the START and WRITE ready terms.
module gpu_lane_tracker
  import gpu_cmd_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] tile_done_i,
  input  logic                 writer_reading_i,
  input  logic                 start_acc_i,
  input  logic                 write_acc_i,
  output logic [NUM_LANES-1:0] dirty_o,
  output logic [NUM_LANES-1:0] buf_sel_o,
  output logic [LANE_W-1:0]    start_ptr_o,
  output logic [LANE_W-1:0]    wb_ptr_o,
  output logic                 start_rdy_o,
  output logic                 write_rdy_o
);

  logic [NUM_LANES-1:0] dirty_q, dirty_d;
  logic [NUM_LANES-1:0] buf_sel_q, buf_sel_d;
  logic [LANE_W-1:0]    start_ptr_q, start_ptr_d;
  logic [LANE_W-1:0]    wb_ptr_q, wb_ptr_d;

  function automatic logic [LANE_W-1:0] next_ptr(input logic [LANE_W-1:0] p);
    if (p == LANE_W'(NUM_LANES - 1)) return '0;
    return p + 1'b1;
  endfunction

  // A lane that was started stays dirty until its tile has been written back,
  // which keeps a second START off it even while tile_done is still high.
  assign start_rdy_o = tile_done_i[start_ptr_q] & ~dirty_q[start_ptr_q];
  assign write_rdy_o = dirty_q[wb_ptr_q] & tile_done_i[wb_ptr_q] & ~writer_reading_i;

  always_comb begin
    dirty_d     = dirty_q;
    buf_sel_d   = buf_sel_q;
    start_ptr_d = start_ptr_q;
    wb_ptr_d    = wb_ptr_q;
    if (start_acc_i) begin
      dirty_d[start_ptr_q] = 1'b1;
      start_ptr_d          = next_ptr(start_ptr_q);
    end
    if (write_acc_i) begin
      dirty_d[wb_ptr_q]   = 1'b0;
      buf_sel_d[wb_ptr_q] = ~buf_sel_q[wb_ptr_q];
      wb_ptr_d            = next_ptr(wb_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dirty_q     <= '0;
      buf_sel_q   <= '0;
      start_ptr_q <= '0;
      wb_ptr_q    <= '0;
    end else begin
      dirty_q     <= dirty_d;
      buf_sel_q   <= buf_sel_d;
      start_ptr_q <= start_ptr_d;
      wb_ptr_q    <= wb_ptr_d;
    end
  end

  assign dirty_o     = dirty_q;
  assign buf_sel_o   = buf_sel_q;
  assign start_ptr_o = start_ptr_q;
  assign wb_ptr_o    = wb_ptr_q;

endmodule

// File: rtl/gpu_cmd_dispatch.sv
// GPU command front end: triangle parameter registers, control opcode decode,
// round-robin tile-raster dispatch and in-order write-back issue.
module gpu_cmd_dispatch
  import gpu_cmd_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                        gpu_clk,
  input  logic                        gpu_rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [3:0]                  cmd_addr,
  input  logic [31:0]                 cmd_data,
  output logic [NUM_LANES-1:0]        tile_start,
  input  logic [NUM_LANES-1:0]        tile_done,
  output logic                        clear_out,
  output logic [NUM_LANES-1:0]        buf_sel,
  output logic                        writer_start,
  output logic [LANE_W-1:0]           writer_lane,
  input  logic                        writer_reading,
  input  logic                        writer_flushed,
  output logic [COLOR_W-1:0]          color,
  output logic signed [EDGE_A_W-1:0]  a01,
  output logic signed [EDGE_A_W-1:0]  a12,
  output logic signed [EDGE_A_W-1:0]  a20,
  output logic signed [EDGE_B_W-1:0]  b01,
  output logic signed [EDGE_B_W-1:0]  b12,
  output logic signed [EDGE_B_W-1:0]  b20,
  output logic signed [WORD_W-1:0]    w0,
  output logic signed [WORD_W-1:0]    w1,
  output logic signed [WORD_W-1:0]    w2,
  output logic [WORD_W-1:0]           base_addr,
  output logic [STRIDE_W-1:0]         stride,
  output logic [WORD_W-1:0]           zx_raw,
  output logic [WORD_W-1:0]           zy_raw,
  output logic [WORD_W-1:0]           zc_raw,
  output logic                        busy,
  output logic [7:0]                  bad_cmd_count
);

  // Handshake: a command is taken on any cycle where cmd_valid and cmd_ready
  // are both high; cmd_ready never depends on anything registered after the
  // accept, and a stalled opcode holds cmd_ready low for everything behind it.
  cmd_kind_e            kind;
  logic                 accept, start_acc, write_acc, reg_acc;
  logic                 start_rdy, write_rdy;
  logic [NUM_LANES-1:0] dirty;
  logic [LANE_W-1:0]    start_ptr, wb_ptr;

  logic [COLOR_W-1:0]         color_q, color_d;
  logic signed [EDGE_A_W-1:0] a01_q, a01_d, a12_q, a12_d, a20_q, a20_d;
  logic signed [EDGE_B_W-1:0] b01_q, b01_d, b12_q, b12_d, b20_q, b20_d;
  logic signed [WORD_W-1:0]   w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
  logic [WORD_W-1:0]          base_q, base_d, zx_q, zx_d, zy_q, zy_d, zc_q, zc_d;
  logic [STRIDE_W-1:0]        stride_q, stride_d;
  logic                       clear_q, clear_d;
  logic [7:0]                 bad_q, bad_d;

  assign kind = decode_cmd(cmd_addr, cmd_data[3:0]);

  always_comb begin
    cmd_ready = 1'b0;
    if (!gpu_rst) begin
      case (kind)
        CMD_REG:   cmd_ready = 1'b1;
        CMD_START: cmd_ready = start_rdy;
        CMD_WRITE: cmd_ready = write_rdy;
        CMD_FLUSH: cmd_ready = writer_flushed;
        CMD_RSTST: cmd_ready = 1'b1;
        CMD_FENCE: cmd_ready = (&tile_done) & writer_flushed & ~writer_reading;
        default:   cmd_ready = 1'b1;
      endcase
    end
  end

  assign accept    = cmd_valid & cmd_ready;
  assign start_acc = accept && (kind == CMD_START);
  assign write_acc = accept && (kind == CMD_WRITE);
  assign reg_acc   = accept && (kind == CMD_REG);

  gpu_lane_tracker #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W)
  ) u_lanes (
    .clk              (gpu_clk),
    .rst              (gpu_rst),
    .tile_done_i      (tile_done),
    .writer_reading_i (writer_reading),
    .start_acc_i      (start_acc),
    .write_acc_i      (write_acc),
    .dirty_o          (dirty),
    .buf_sel_o        (buf_sel),
    .start_ptr_o      (start_ptr),
    .wb_ptr_o         (wb_ptr),
    .start_rdy_o      (start_rdy),
    .write_rdy_o      (write_rdy)
  );

  always_comb begin
    tile_start = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      tile_start[i] = start_acc && (start_ptr == LANE_W'(i));
    end
  end

  assign writer_start = write_acc;
  assign writer_lane  = write_acc ? wb_ptr : '0;

  always_comb begin
    color_d  = color_q;
    a01_d    = a01_q;
    a12_d    = a12_q;
    a20_d    = a20_q;
    b01_d    = b01_q;
    b12_d    = b12_q;
    b20_d    = b20_q;
    w0_d     = w0_q;
    w1_d     = w1_q;
    w2_d     = w2_q;
    base_d   = base_q;
    stride_d = stride_q;
    zx_d     = zx_q;
    zy_d     = zy_q;
    zc_d     = zc_q;
    if (reg_acc) begin
      case (cmd_addr)
        REG_COLOR:  color_d  = cmd_data[COLOR_W-1:0];
        REG_A01:    a01_d    = cmd_data[EDGE_A_W-1:0];
        REG_A12:    a12_d    = cmd_data[EDGE_A_W-1:0];
        REG_A20:    a20_d    = cmd_data[EDGE_A_W-1:0];
        REG_W0:     w0_d     = cmd_data;
        REG_W1:     w1_d     = cmd_data;
        REG_W2:     w2_d     = cmd_data;
        REG_BASE:   base_d   = cmd_data;
        REG_STRIDE: stride_d = cmd_data[STRIDE_W-1:0];
        REG_B01:    b01_d    = cmd_data[EDGE_B_W-1:0];
        REG_B12:    b12_d    = cmd_data[EDGE_B_W-1:0];
        REG_B20:    b20_d    = cmd_data[EDGE_B_W-1:0];
        REG_ZX:     zx_d     = cmd_data;
        REG_ZY:     zy_d     = cmd_data;
        REG_ZC:     zc_d     = cmd_data;
        default:    ;
      endcase
    end
  end

  // clear is what the next started lane samples: set by write-back or
  // RESET_STATE, consumed by the following START.
  always_comb begin
    clear_d = clear_q;
    bad_d   = bad_q;
    if (start_acc) clear_d = 1'b0;
    if (write_acc || (accept && kind == CMD_RSTST)) clear_d = 1'b1;
    if (accept && kind == CMD_BAD && bad_q != 8'hFF) bad_d = bad_q + 8'd1;
  end

  always_ff @(posedge gpu_clk) begin
    if (gpu_rst) begin
      color_q  <= '0;
      a01_q    <= '0;
      a12_q    <= '0;
      a20_q    <= '0;
      b01_q    <= '0;
      b12_q    <= '0;
      b20_q    <= '0;
      w0_q     <= '0;
      w1_q     <= '0;
      w2_q     <= '0;
      base_q   <= '0;
      stride_q <= '0;
      zx_q     <= '0;
      zy_q     <= '0;
      zc_q     <= '0;
      clear_q  <= 1'b0;
      bad_q    <= '0;
    end else begin
      color_q  <= color_d;
      a01_q    <= a01_d;
      a12_q    <= a12_d;
      a20_q    <= a20_d;
      b01_q    <= b01_d;
      b12_q    <= b12_d;
      b20_q    <= b20_d;
      w0_q     <= w0_d;
      w1_q     <= w1_d;
      w2_q     <= w2_d;
      base_q   <= base_d;
      stride_q <= stride_d;
      zx_q     <= zx_d;
      zy_q     <= zy_d;
      zc_q     <= zc_d;
      clear_q  <= clear_d;
      bad_q    <= bad_d;
    end
  end

  assign color         = color_q;
  assign a01           = a01_q;
  assign a12           = a12_q;
  assign a20           = a20_q;
  assign b01           = b01_q;
  assign b12           = b12_q;
  assign b20           = b20_q;
  assign w0            = w0_q;
  assign w1            = w1_q;
  assign w2            = w2_q;
  assign base_addr     = base_q;
  assign stride        = stride_q;
  assign zx_raw        = zx_q;
  assign zy_raw        = zy_q;
  assign zc_raw        = zc_q;
  assign clear_out     = clear_q;
  assign bad_cmd_count = bad_q;
  assign busy          = (|dirty) | ~(&tile_done) | ~writer_flushed;

endmodule

// File: tb/tb_gpu_cmd_dispatch.sv
// Directed bench for gpu_cmd_dispatch with two lanes: register map, round-robin
// dispatch, write-back stalls, fence/flush, bad-opcode saturation and reset.
module tb_gpu_cmd_dispatch;
  import gpu_cmd_pkg::*;

  localparam int NL = 2;

  logic          gpu_clk = 1'b0;
  logic          gpu_rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_addr;
  logic [31:0]   cmd_data;
  logic [NL-1:0] tile_start;
  logic [NL-1:0] tile_done;
  logic          clear_out;
  logic [NL-1:0] buf_sel;
  logic          writer_start;
  logic [0:0]    writer_lane;
  logic          writer_reading;
  logic          writer_flushed;
  logic [15:0]   color;
  logic signed [18:0] a01, a12, a20;
  logic signed [23:0] b01, b12, b20;
  logic signed [31:0] w0, w1, w2;
  logic [31:0]   base_addr;
  logic [15:0]   stride;
  logic [31:0]   zx_raw, zy_raw, zc_raw;
  logic          busy;
  logic [7:0]    bad_cmd_count;

  int checks   = 0;
  int failures = 0;

  logic [NL-1:0] acc_tile_start;
  logic          acc_writer_start;
  logic [0:0]    acc_writer_lane;
  logic [31:0]   exp_reg [16];
  logic [NL-1:0] exp_q [$];

  gpu_cmd_dispatch #(.NUM_LANES(NL)) dut (
    .gpu_clk        (gpu_clk),
    .gpu_rst        (gpu_rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_addr       (cmd_addr),
    .cmd_data       (cmd_data),
    .tile_start     (tile_start),
    .tile_done      (tile_done),
    .clear_out      (clear_out),
    .buf_sel        (buf_sel),
    .writer_start   (writer_start),
    .writer_lane    (writer_lane),
    .writer_reading (writer_reading),
    .writer_flushed (writer_flushed),
    .color          (color),
    .a01            (a01),
    .a12            (a12),
    .a20            (a20),
    .b01            (b01),
    .b12            (b12),
    .b20            (b20),
    .w0             (w0),
    .w1             (w1),
    .w2             (w2),
    .base_addr      (base_addr),
    .stride         (stride),
    .zx_raw         (zx_raw),
    .zy_raw         (zy_raw),
    .zc_raw         (zc_raw),
    .busy           (busy),
    .bad_cmd_count  (bad_cmd_count)
  );

  // clock / reset
  always #5 gpu_clk = ~gpu_clk;

  function automatic logic [31:0] reg_view(input logic [3:0] a);
    case (a)
      4'd1:    return {16'h0, color};
      4'd2:    return {13'h0, a01};
      4'd3:    return {13'h0, a12};
      4'd4:    return {13'h0, a20};
      4'd5:    return w0;
      4'd6:    return w1;
      4'd7:    return w2;
      4'd8:    return base_addr;
      4'd9:    return {16'h0, stride};
      4'd10:   return {8'h0, b01};
      4'd11:   return {8'h0, b12};
      4'd12:   return {8'h0, b20};
      4'd13:   return zx_raw;
      4'd14:   return zy_raw;
      default: return zc_raw;
    endcase
  endfunction

  function automatic logic [31:0] reg_mask(input logic [3:0] a);
    if (a == 4'd1 || a == 4'd9) return 32'h0000_FFFF;
    if (a >= 4'd2 && a <= 4'd4) return 32'h0007_FFFF;
    if (a >= 4'd10 && a <= 4'd12) return 32'h00FF_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  // driver: present one command, wait up to budget cycles for ready, capture pulses
  task automatic send(input logic [3:0] addr, input logic [31:0] data,
                      input int budget, output bit ok);
    int n;
    n = 0;
    @(negedge gpu_clk);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_data  = data;
    #1;
    while (!cmd_ready && n < budget) begin
      @(negedge gpu_clk);
      #1;
      n++;
    end
    ok               = cmd_ready;
    acc_tile_start   = tile_start;
    acc_writer_start = writer_start;
    acc_writer_lane  = writer_lane;
    @(posedge gpu_clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    gpu_rst = 1'b1; cmd_valid = 1'b1; cmd_addr = REG_COLOR; cmd_data = 32'h1111;
    tile_done = 2'b11; writer_reading = 1'b0; writer_flushed = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", cmd_ready); end
    repeat (2) @(posedge gpu_clk);
    #1;
    checks++; if (color !== 16'h0) begin failures++; $display("FAIL rst_color got=%h exp=0", color); end
    checks++; if (bad_cmd_count !== 8'h0) begin failures++; $display("FAIL rst_bad got=%h exp=0", bad_cmd_count); end
    checks++; if (buf_sel !== 2'b00 || clear_out !== 1'b0) begin failures++; $display("FAIL rst_bufsel_clear got=%b/%b exp=00/0", buf_sel, clear_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (tile_start !== 2'b00 || writer_start !== 1'b0) begin failures++; $display("FAIL rst_pulses got=%b/%b exp=00/0", tile_start, writer_start); end
    @(negedge gpu_clk);
    gpu_rst = 1'b0; cmd_valid = 1'b0;
    for (int a = 0; a < 16; a++) exp_reg[a] = 32'h0;
  endtask

  task automatic test_reg_write();
    bit ok;
    send(REG_COLOR, 32'h0000_ABCD, 2, ok);
    checks++; if (color !== 16'hABCD) begin failures++; $display("FAIL color got=%h exp=abcd", color); end
    checks++; if (bad_cmd_count !== 8'h0) begin failures++; $display("FAIL reg_bad got=%h exp=0", bad_cmd_count); end
    exp_reg[1] = 32'h0000_ABCD;
    for (int a = 2; a < 16; a++) begin
      logic [31:0] d;
      d = 32'hF1E2_D3C4 ^ (32'(a) * 32'h0111_1111);
      send(4'(a), d, 2, ok);
      exp_reg[a] = d & reg_mask(4'(a));
      checks++;
      if (!ok || reg_view(4'(a)) !== exp_reg[a]) begin
        failures++; $display("FAIL reg_%0d got=%h exp=%h", a, reg_view(4'(a)), exp_reg[a]);
      end
    end
    send(REG_A01, 32'hFFFF_FFFF, 2, ok);
    exp_reg[2] = 32'h0007_FFFF;
    checks++; if (a01 !== -19'sd1) begin failures++; $display("FAIL a01_neg got=%h exp=7ffff", a01); end
  endtask

  task automatic test_back_to_back();
    @(negedge gpu_clk);
    cmd_valid = 1'b1; cmd_addr = REG_STRIDE; cmd_data = 32'hBEEF_1234;
    @(negedge gpu_clk);
    checks++; if (stride !== 16'h1234) begin failures++; $display("FAIL b2b_stride got=%h exp=1234", stride); end
    cmd_addr = REG_A12; cmd_data = 32'h0005_5555;
    @(negedge gpu_clk);
    cmd_valid = 1'b0;
    checks++; if (a12 !== 19'h55555) begin failures++; $display("FAIL b2b_a12 got=%h exp=55555", a12); end
    exp_reg[9] = 32'h0000_1234;
    exp_reg[3] = 32'h0005_5555;
  endtask

  task automatic test_start_round_robin();
    bit ok;
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    tile_done = 2'b11;
    for (int i = 0; i < 2; i++) begin
      logic [NL-1:0] e;
      send(4'd0, {28'h0, OP_START}, 2, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || acc_tile_start !== e) begin failures++; $display("FAIL start_%0d got=%b exp=%b", i, acc_tile_start, e); end
    end
    checks++; if (tile_start !== 2'b00) begin failures++; $display("FAIL start_one_cycle got=%b exp=00", tile_start); end
    @(negedge gpu_clk);
    tile_done = 2'b00;
    cmd_valid = 1'b1; cmd_addr = 4'd0; cmd_data = {28'h0, OP_START};
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL start3_stall got=%b exp=0", cmd_ready); end
      @(negedge gpu_clk);
      tile_done = 2'b01;
      #1;
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_dirty got=%b exp=1", busy); end
    cmd_valid = 1'b0;
  endtask

  task automatic test_write_stall();
    bit ok;
    @(negedge gpu_clk);
    tile_done = 2'b01; writer_reading = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 4'd0; cmd_data = {28'h0, OP_WRITE};
    #1;
    checks++; if (cmd_ready !== 1'b0 || writer_start !== 1'b0) begin failures++; $display("FAIL write_stall got=%b/%b exp=0/0", cmd_ready, writer_start); end
    @(negedge gpu_clk);
    writer_reading = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1 || writer_start !== 1'b1 || writer_lane !== 1'b0) begin
      failures++; $display("FAIL write_go got=%b/%b/%b exp=1/1/0", cmd_ready, writer_start, writer_lane);
    end
    @(posedge gpu_clk);
    #1 cmd_valid = 1'b0;
    checks++; if (buf_sel !== 2'b01 || clear_out !== 1'b1) begin failures++; $display("FAIL write_state got=%b/%b exp=01/1", buf_sel, clear_out); end
    checks++; if (writer_start !== 1'b0) begin failures++; $display("FAIL write_one_cycle got=%b exp=0", writer_start); end
    send(4'd0, {28'h0, OP_START}, 2, ok);
    checks++; if (!ok || acc_tile_start !== 2'b01) begin failures++; $display("FAIL start_after_wb got=%b exp=01", acc_tile_start); end
    checks++; if (clear_out !== 1'b0) begin failures++; $display("FAIL clear_after_start got=%b exp=0", clear_out); end
    tile_done = 2'b00;
  endtask

  task automatic test_reset_state();
    bit ok;
    send(4'd0, {28'h0, OP_RESET}, 2, ok);
    checks++; if (!ok || clear_out !== 1'b1) begin failures++; $display("FAIL reset_state_clear got=%b exp=1", clear_out); end
  endtask

  task automatic test_write_lane1();
    bit ok;
    @(negedge gpu_clk);
    tile_done = 2'b10;
    send(4'd0, {28'h0, OP_WRITE}, 3, ok);
    checks++; if (!ok || acc_writer_start !== 1'b1 || acc_writer_lane !== 1'b1) begin
      failures++; $display("FAIL wb_lane1 got=%b/%b exp=1/1", acc_writer_start, acc_writer_lane);
    end
    checks++; if (buf_sel !== 2'b11) begin failures++; $display("FAIL wb_lane1_bufsel got=%b exp=11", buf_sel); end
  endtask

  task automatic test_fence_flush();
    bit ok;
    @(negedge gpu_clk);
    tile_done = 2'b10; writer_flushed = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 4'd0; cmd_data = {28'h0, OP_FENCE};
    #1;
    repeat (2) begin
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL fence_stall got=%b exp=0", cmd_ready); end
      @(negedge gpu_clk);
      #1;
    end
    tile_done = 2'b11; writer_flushed = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL fence_go got=%b exp=1", cmd_ready); end
    @(posedge gpu_clk);
    #1 cmd_valid = 1'b0;
    writer_flushed = 1'b0;
    @(negedge gpu_clk);
    cmd_valid = 1'b1; cmd_data = {28'h0, OP_FLUSH};
    #1;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", cmd_ready); end
    @(negedge gpu_clk);
    writer_flushed = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL flush_go got=%b exp=1", cmd_ready); end
    @(posedge gpu_clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_writeback_order();
    bit ok;
    tile_done = 2'b11;
    send(4'd0, {28'h0, OP_WRITE}, 3, ok);
    checks++; if (!ok || acc_writer_lane !== 1'b0 || buf_sel !== 2'b10) begin
      failures++; $display("FAIL wb_order got=%b/%b exp=0/10", acc_writer_lane, buf_sel);
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_idle got=%b exp=0", busy); end
  endtask

  task automatic test_bad_opcodes();
    bit ok;
    int okc;
    logic [3:0] ops [11];
    okc = 0;
    ops[0] = 4'd1; ops[1] = 4'd3;
    for (int i = 2; i < 11; i++) ops[i] = 4'(i + 5);
    for (int i = 0; i < 11; i++) begin
      send(4'd0, {28'h0, ops[i]}, 2, ok);
      if (ok) okc++;
    end
    checks++; if (okc != 11 || bad_cmd_count !== 8'd11) begin failures++; $display("FAIL bad_count11 got=%0d exp=11", bad_cmd_count); end
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [3:0] op;
      r = $urandom_range(0, 10);
      op = (r == 0) ? 4'd1 : (r == 1) ? 4'd3 : 4'(r + 5);
      send(4'd0, {$urandom_range(0, 255), 20'h0, op} & 32'hFF00_000F, 2, ok);
    end
    checks++; if (bad_cmd_count !== 8'd255) begin failures++; $display("FAIL bad_saturate got=%0d exp=255", bad_cmd_count); end
    for (int a = 1; a < 16; a++) begin
      checks++; if (reg_view(4'(a)) !== exp_reg[a]) begin failures++; $display("FAIL bad_keep_%0d got=%h exp=%h", a, reg_view(4'(a)), exp_reg[a]); end
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    tile_done = 2'b11;
    send(4'd0, {28'h0, OP_START}, 2, ok);
    checks++; if (!ok || acc_tile_start !== 2'b10) begin failures++; $display("FAIL mr_start1 got=%b exp=10", acc_tile_start); end
    send(4'd0, {28'h0, OP_START}, 2, ok);
    checks++; if (!ok || acc_tile_start !== 2'b01) begin failures++; $display("FAIL mr_start0 got=%b exp=01", acc_tile_start); end
    @(negedge gpu_clk);
    gpu_rst = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 4'd0; cmd_data = {28'h0, OP_WRITE};
    #1;
    checks++; if (cmd_ready !== 1'b0 || writer_start !== 1'b0 || tile_start !== 2'b00) begin
      failures++; $display("FAIL mr_rst_cycle got=%b/%b/%b exp=0/0/00", cmd_ready, writer_start, tile_start);
    end
    @(posedge gpu_clk);
    #1;
    checks++; if (color !== 16'h0 || a01 !== 19'h0 || w0 !== 32'h0 || base_addr !== 32'h0 || stride !== 16'h0 || zc_raw !== 32'h0) begin
      failures++; $display("FAIL mr_regs got=%h/%h/%h/%h exp=0", color, a01, w0, stride);
    end
    checks++; if (buf_sel !== 2'b00 || clear_out !== 1'b0 || bad_cmd_count !== 8'h0 || writer_lane !== 1'b0) begin
      failures++; $display("FAIL mr_state got=%b/%b/%h/%b exp=00/0/00/0", buf_sel, clear_out, bad_cmd_count, writer_lane);
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mr_busy got=%b exp=0", busy); end
    @(negedge gpu_clk);
    gpu_rst = 1'b0; cmd_valid = 1'b0;
    send(4'd0, {28'h0, OP_START}, 2, ok);
    checks++; if (!ok || acc_tile_start !== 2'b01) begin failures++; $display("FAIL mr_restart got=%b exp=01", acc_tile_start); end
  endtask

  initial begin
    test_reset();
    test_reg_write();
    test_back_to_back();
    test_start_round_robin();
    test_write_stall();
    test_reset_state();
    test_write_lane1();
    test_fence_flush();
    test_writeback_order();
    test_bad_opcodes();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
